// File: rtl/axrm_pkg.sv
// axrm_pkg: shared state encoding and width helpers for the error-sweep engine
package axrm_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  localparam int WIDTH_DEF = 8;
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction
  function automatic int sum_w(input int w);
    return 4 * w;
  endfunction
endpackage

// File: rtl/axrm_err_sweep_if.sv
// axrm_err_sweep_if: operand/product link between the sweep engine and the multiplier under test
interface axrm_err_sweep_if import axrm_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2*WIDTH-1:0] approx_y;
  modport master(output op_a, op_b, input approx_y);
  modport slave(input op_a, op_b, output approx_y);
endinterface

// File: rtl/axrm_align_pipe.sv
// axrm_align_pipe: DEPTH-stage delay line for {valid, a, b}; depth 0 is a wire-through
module axrm_align_pipe #(
  parameter int DEPTH = 0,
  parameter int DW = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] d_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst};
    assign d_o = d_i;
  end else begin : g_pipe
    logic [DW-1:0] p_q [DEPTH];
    // shift register; reset clears the valid bit carried in the MSB along with the data
    always_ff @(posedge clk or posedge rst) begin
      if (rst) p_q <= '{default: '0};
      else begin
        p_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) p_q[i] <= p_q[i-1];
      end
    end
    assign d_o = p_q[DEPTH-1];
  end
endmodule

// File: rtl/axrm_err_sweep.sv
// axrm_err_sweep: exhaustive error sweep of an approximate multiplier; AXRM_ERR_BIAS_EN adds signed bias output
module axrm_err_sweep import axrm_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PROD_LAT = 0,
  parameter int CNT_W = cnt_w(WIDTH),
  parameter int SUM_W = sum_w(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  axrm_err_sweep_if.master mul,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] test_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [2*WIDTH-1:0] max_ed
`ifdef AXRM_ERR_BIAS_EN
  ,
  output logic signed [SUM_W:0] err_bias
`endif
);
  localparam int PW = 2 * WIDTH;
  localparam int DRN_W = $clog2(PROD_LAT + 2);
  state_t state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [CNT_W-1:0] tc_q, ec_q;
  logic [SUM_W-1:0] sum_q;
  logic [PW-1:0] max_q;
  logic [PW:0] pi, po;
  logic [PW-1:0] ex, ed;
  logic s_v, last, clr;
  assign last = idx_q == '1;
  assign mul.op_a = idx_q[PW-1:WIDTH];
  assign mul.op_b = idx_q[WIDTH-1:0];
  assign pi = {state_q == SWEEP, idx_q};
  axrm_align_pipe #(.DEPTH(PROD_LAT), .DW(PW + 1)) u_pipe (.clk, .rst, .d_i(pi), .d_o(po));
  assign s_v = po[PW];
  assign ex = PW'(po[PW-1:WIDTH]) * PW'(po[WIDTH-1:0]);
  assign ed = ex > mul.approx_y ? ex - mul.approx_y : mul.approx_y - ex;
  assign busy = state_q == SWEEP || state_q == DRAIN;
  assign done = state_q == DONE;
  assign test_cnt = tc_q;
  assign err_cnt = ec_q;
  assign sum_ed = sum_q;
  assign max_ed = max_q;
  // next state: idx stops at all-ones so operands hold their final pair after the sweep
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    drn_d = drn_q;
    clr = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SWEEP;
        idx_d = '0;
        clr = 1'b1;
      end
      SWEEP: begin
        idx_d = last ? idx_q : idx_q + 1'b1;
        drn_d = '0;
        if (last) state_d = PROD_LAT > 0 ? DRAIN : DONE;
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_W'(PROD_LAT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      drn_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      drn_q <= drn_d;
    end
  end
  // accumulate one sample whenever an aligned product is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      tc_q <= '0;
      ec_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (s_v) begin
      tc_q <= tc_q + 1'b1;
      ec_q <= ec_q + CNT_W'(ed != '0);
      sum_q <= sum_q + SUM_W'(ed);
      max_q <= ed > max_q ? ed : max_q;
    end
  end
`ifdef AXRM_ERR_BIAS_EN
  logic signed [SUM_W:0] bias_q;
  logic signed [PW:0] bd;
  assign bd = $signed({1'b0, mul.approx_y}) - $signed({1'b0, ex});
  assign err_bias = bias_q;
  // signed running sum of approx - exact
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) bias_q <= '0;
    else if (s_v) bias_q <= bias_q + {{(SUM_W - PW){bd[PW]}}, bd};
  end
`endif
endmodule

// File: tb/tb_axrm_err_sweep.sv
// tb_axrm_err_sweep: scoreboard bench for two sweep engines (PROD_LAT 0 and 2) at WIDTH 4
module tb_axrm_err_sweep;
  localparam int W = 4;
  localparam int PW = 8;
  localparam int CW = 9;
  localparam int SW = 16;
  typedef struct {int tc; int ec; int sum; int mx; int lat; int bsy; int bias;} exp_t;
  logic clk = 0;
  logic rst = 1;
  logic start0 = 0;
  logic start2 = 0;
  int mode = 0;
  int cyc = 0;
  int st0 = 0, st2 = 0, bc0 = 0, bc2 = 0;
  int n_chk = 0, n_pass = 0;
  exp_t q0[$];
  exp_t q2[$];
  logic busy0, done0, busy2, done2;
  logic [CW-1:0] tc0, ec0, tc2, ec2;
  logic [SW-1:0] se0, se2;
  logic [PW-1:0] mx0, mx2, r1, r2;
`ifdef AXRM_ERR_BIAS_EN
  logic signed [SW:0] eb0, eb2;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  axrm_err_sweep_if #(.WIDTH(W)) m0();
  axrm_err_sweep_if #(.WIDTH(W)) m2();
  function automatic logic [PW-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return m == 1 ? '0 : m == 2 ? p ^ 8'h01 : p;
  endfunction
  assign m0.approx_y = fmul(m0.op_a, m0.op_b, mode);
  always @(posedge clk) begin
    r1 <= fmul(m2.op_a, m2.op_b, mode);
    r2 <= r1;
  end
  assign m2.approx_y = r2;
  axrm_err_sweep #(.WIDTH(W), .PROD_LAT(0)) d0 (
    .clk(clk), .rst(rst), .start(start0), .mul(m0), .busy(busy0), .done(done0),
    .test_cnt(tc0), .err_cnt(ec0), .sum_ed(se0), .max_ed(mx0)
`ifdef AXRM_ERR_BIAS_EN
    , .err_bias(eb0)
`endif
  );
  axrm_err_sweep #(.WIDTH(W), .PROD_LAT(2)) d2 (
    .clk(clk), .rst(rst), .start(start2), .mul(m2), .busy(busy2), .done(done2),
    .test_cnt(tc2), .err_cnt(ec2), .sum_ed(se2), .max_ed(mx2)
`ifdef AXRM_ERR_BIAS_EN
    , .err_bias(eb2)
`endif
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic cmp(input string p, input exp_t a, input exp_t e);
    chk({p, "_test_cnt"}, a.tc, e.tc);
    chk({p, "_err_cnt"}, a.ec, e.ec);
    chk({p, "_sum_ed"}, a.sum, e.sum);
    chk({p, "_max_ed"}, a.mx, e.mx);
    chk({p, "_latency"}, a.lat, e.lat);
    chk({p, "_busy_cycles"}, a.bsy, e.bsy);
`ifdef AXRM_ERR_BIAS_EN
    chk({p, "_err_bias"}, a.bias, e.bias);
`endif
  endtask
  always @(negedge clk) begin
    exp_t a, e;
    if (rst) begin
      bc0 = 0;
      bc2 = 0;
    end else begin
      if (busy0) bc0++;
      if (busy2) bc2++;
      if (done0) begin
        a = '{int'(tc0), int'(ec0), int'(se0), int'(mx0), cyc - st0, bc0, 0};
`ifdef AXRM_ERR_BIAS_EN
        a.bias = int'(eb0);
`endif
        if (q0.size() == 0) chk("d0_unexpected_done", 1, 0);
        else begin
          e = q0.pop_front();
          cmp("d0", a, e);
        end
        bc0 = 0;
      end
      if (done2) begin
        a = '{int'(tc2), int'(ec2), int'(se2), int'(mx2), cyc - st2, bc2, 0};
`ifdef AXRM_ERR_BIAS_EN
        a.bias = int'(eb2);
`endif
        if (q2.size() == 0) chk("d2_unexpected_done", 1, 0);
        else begin
          e = q2.pop_front();
          cmp("d2", a, e);
        end
        bc2 = 0;
      end
    end
  end
  task automatic go(input int d, input int m, input exp_t e, input int spam);
    mode = m;
    if (d == 0) q0.push_back(e);
    else q2.push_back(e);
    @(posedge clk); #1;
    if (d == 0) begin
      start0 = 1;
      st0 = cyc;
    end else begin
      start2 = 1;
      st2 = cyc;
    end
    @(posedge clk); #1;
    start0 = 0;
    start2 = 0;
    for (int i = 0; i < 400; i++) begin
      if (d == 0 ? done0 : done2) break;
      start0 = spam != 0 && i == 50;
      @(posedge clk); #1;
    end
    start0 = 0;
    if (!(d == 0 ? done0 : done2)) chk("done_timeout", 0, 1);
    else if (spam != 0) begin
      start0 = 1;
      @(posedge clk); #1;
      start0 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("start_in_done_ignored_busy", busy0, 0);
      chk("hold_test_cnt", tc0, 256);
      chk("hold_idx", {m0.op_a, m0.op_b}, 255);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ops", {m0.op_a, m0.op_b}, 0);
    chk("rst_test_cnt", tc0, 0);
    chk("rst_err_cnt", ec0, 0);
    chk("rst_sum_ed", se0, 0);
    chk("rst_max_ed", mx0, 0);
    chk("rst_d2_busy", busy2, 0);
    rst = 0;
    go(0, 0, '{256, 0, 0, 0, 257, 256, 0}, 0);
    go(0, 1, '{256, 225, 14400, 225, 257, 256, -14400}, 0);
    go(0, 2, '{256, 256, 256, 1, 257, 256, 128}, 0);
    go(2, 0, '{256, 0, 0, 0, 259, 258, 0}, 0);
    go(2, 2, '{256, 256, 256, 1, 259, 258, 128}, 0);
    mode = 1;
    @(posedge clk); #1;
    start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    for (int i = 0; i < 300; i++) begin
      if ({m0.op_a, m0.op_b} == 8'd100) break;
      @(posedge clk); #1;
    end
    chk("mid_sweep_reached", {m0.op_a, m0.op_b}, 100);
    rst = 1;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_ops", {m0.op_a, m0.op_b}, 0);
    chk("abort_test_cnt", tc0, 0);
    chk("abort_err_cnt", ec0, 0);
    chk("abort_sum_ed", se0, 0);
    chk("abort_max_ed", mx0, 0);
`ifdef AXRM_ERR_BIAS_EN
    chk("abort_err_bias", eb0, 0);
`endif
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_stays_idle", busy0, 0);
    go(0, 0, '{256, 0, 0, 0, 257, 256, 0}, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("d0_scoreboard_empty", q0.size(), 0);
    chk("d2_scoreboard_empty", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axrm_err_sweep.md
Name: axrm_err_sweep

Overview:
- Exhaustive error-characterisation engine that sits directly upstream and downstream of an approximate WIDTHxWIDTH multiplier.
- Drives every operand pair into the multiplier's a/b inputs, one pair per cycle.
- Consumes the multiplier's product, compares it against an internally computed exact product, and accumulates:
  - error count
  - sum of error distances
  - maximum error distance
- Replaces offline testbench accuracy tallies with a synthesizable on-chip monitor.

Parameters:
- WIDTH, 8, operand width of the multiplier under test.
- PROD_LAT, 0, cycles from op_a/op_b change to the matching approx_y (0 = combinational multiplier).
- CNT_W, 2*WIDTH+1, width of the test and error counters (must hold 2^(2*WIDTH)).
- SUM_W, 4*WIDTH, width of the error-distance accumulator.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when in IDLE.
- op_a  out  WIDTH  operand a to the multiplier.
- op_b  out  WIDTH  operand b to the multiplier.
- approx_y  in  2*WIDTH  product returned by the multiplier.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- test_cnt  out  CNT_W  number of pairs evaluated.
- err_cnt  out  CNT_W  pairs with approx_y != exact.
- sum_ed  out  SUM_W  sum of |exact - approx_y|.
- max_ed  out  2*WIDTH  largest error distance seen.

Behaviour:
- Reset (async, rst high):
  - State goes to IDLE.
  - op_a, op_b, busy, done, test_cnt, err_cnt, sum_ed and max_ed all go to 0.
  - The alignment pipe is cleared (valid bits 0).
- Operand generation:
  - idx is a 2*WIDTH-bit counter.
  - op_a = idx[2W-1:W] and op_b = idx[W-1:0], driven from registers.
  - Order: a major, b minor, starting at 0/0.
- Alignment:
  - op_a, op_b and an issue-valid bit pass through a PROD_LAT-deep delay line.
  - approx_y is sampled in the cycle the delayed valid is high.
- Exact product:
  - Full-width unsigned delayed_a*delayed_b, 2*WIDTH bits, with no truncation.
- Error distance ed = |exact - approx_y|, computed unsigned as the larger minus the smaller.
- Accumulation, registered at the end of each sample cycle:
  - test_cnt += 1.
  - err_cnt += (ed != 0).
  - sum_ed += ed, zero-extended to SUM_W.
  - max_ed = max(max_ed, ed).
- FSM:
  - IDLE: on start, clear all accumulators and idx, and go to SWEEP. start is ignored in every other state.
  - SWEEP: idx increments every cycle.
    - When the all-ones idx is issued, go to DRAIN if PROD_LAT > 0, else go to DONE.
    - The final pair is accumulated in that same cycle when PROD_LAT = 0.
  - DRAIN: count PROD_LAT cycles; the final sample is accumulated in the last DRAIN cycle, then go to DONE.
  - DONE: assert done for exactly one cycle, then go to IDLE.
- Result holding:
  - Results hold in IDLE until the next start.
  - op_a/op_b hold their last value.
- Latency: start to done = 2^(2*WIDTH) + PROD_LAT + 1 cycles.
- Boundaries:
  - The idx wrap from all-ones to 0 never occurs inside a sweep.
  - test_cnt ends at exactly 2^(2*WIDTH).
  - start coinciding with done is ignored.
  - rst mid-sweep aborts immediately to reset values; a new start is required.
- Overflow: the counters and sum_ed cannot overflow at the default widths. Saturation is not required.

Optional Feature:
- Macro: AXRM_ERR_BIAS_EN.
- Defined:
  - Adds output port err_bias, signed, SUM_W+1 bits, reset to 0.
  - err_bias accumulates (approx_y - exact) as a signed value.
  - It is cleared on start and updated in the same cycle as sum_ed.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package axrm_pkg holds:
  - state enum {IDLE, SWEEP, DRAIN, DONE}
  - default WIDTH constant
  - localparam helpers for CNT_W/SUM_W derivation
- Sub-module axrm_align_pipe: parameterised (depth PROD_LAT, data width 2*WIDTH+1) delay line for operands plus valid.
  - Depth 0 is a wire-through.
  - Async-reset valid bits.

Test Plan:
- Exact a*b multiplier, PROD_LAT=0, start:
  - done 65537 cycles after start.
  - test_cnt=65536, err_cnt=0, sum_ed=0, max_ed=0.
- Multiplier tied to 0:
  - err_cnt=65025, sum_ed=1065369600, max_ed=65025.
- Multiplier output (a*b)^1:
  - err_cnt=65536, sum_ed=65536, max_ed=1.
  - With AXRM_ERR_BIAS_EN: err_bias=+32768.
- Exact multiplier registered twice, PROD_LAT=2:
  - err_cnt=0.
  - done 65539 cycles after start.
  - busy high for 65538 cycles.
- Assert rst at idx=1000 mid-sweep:
  - All outputs 0 and state IDLE the same cycle.
  - A subsequent start gives the full clean results of scenario 1.
- start pulsed during SWEEP and in the done cycle: ignored, and test_cnt is still exactly 65536.
